// File: rtl/fifo_scd_flags_if.sv
// Handshake and status bundle for fifo_scd_flags: producer/consumer controls
// plus data, flags, occupancy and sticky error outputs.
interface fifo_scd_flags_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          clr;
  logic          we;
  logic [DW-1:0] din;
  logic          re;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output clr, we, din, re,
    input  dout, dout_vld, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  clr, we, din, re,
    output dout, dout_vld, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_scd_flags.sv
// Single-clock FIFO with standard/FWFT read, occupancy count, programmable
// almost flags, synchronous flush and sticky overflow/underflow.
module fifo_scd_flags #(
  parameter int DEPTH  = 16,
  parameter int DW     = 32,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  fifo_scd_flags_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_TH = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_TH = (AW+1)'(AE_LVL);

  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   rp_q, rp_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_vld_q, dout_vld_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic [AW-1:0] wa, ra;
  logic [AW:0]   count;
  logic          empty, full;
  logic          wr_acc, rd_acc;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign wa     = wp_q[AW-1:0];
  assign ra     = rp_q[AW-1:0];
  assign empty  = (rp_q == wp_q);
  assign full   = (wa == ra) && (wp_q[AW] != rp_q[AW]);
  assign count  = wp_q - rp_q;
  assign wr_acc = bus.we & ~full  & ~bus.clr;
  assign rd_acc = bus.re & ~empty & ~bus.clr;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (bus.clr) begin
      wp_d  = '0;
      rp_d  = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_acc) wp_d = wp_q + 1'b1;
      if (rd_acc) begin
        rp_d       = rp_q + 1'b1;
        dout_d     = mem_q[ra];
        dout_vld_d = 1'b1;
      end
      if (bus.we & full)  ovf_d = 1'b1;
      if (bus.re & empty) udf_d = 1'b1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) mem_d[wa] = bus.din;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  always_comb begin
    if (FWFT != 0) begin
      bus.dout     = mem_q[ra];
      bus.dout_vld = ~empty;
    end else begin
      bus.dout     = dout_q;
      bus.dout_vld = dout_vld_q;
    end
  end

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AF_TH);
  assign bus.almost_empty = (count <= AE_TH);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: doc/fifo_scd_flags.md
Name: fifo_scd_flags

Overview:
- Single-clock synchronous FIFO with a power-of-two parametrised depth and width.
- Extends the basic single-clock FIFO with:
  - selectable standard or first-word-fall-through (FWFT) read mode
  - occupancy count output
  - programmable almost-full and almost-empty thresholds
  - synchronous flush
  - sticky overflow and underflow error flags
- Used as the general buffering element between streaming blocks in the datapath.

Parameters:
- DEPTH, 16: number of DW-wide words. Must be a power of two, ≥ 2.
- DW, 32: data width in bits.
- AF_LVL, 14: almost_full asserts when count ≥ AF_LVL. Legal range 1..DEPTH.
- AE_LVL, 2: almost_empty asserts when count ≤ AE_LVL. Legal range 0..DEPTH-1.
- FWFT, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst, input, 1: asynchronous reset, active-high.
- clr, input, 1: synchronous flush, active-high.
- we, input, 1: write enable.
- din, input, DW: write data.
- re, input, 1: read enable / pop.
- dout, output, DW: read data.
- dout_vld, output, 1: dout holds valid data.
- empty, output, 1: FIFO empty.
- full, output, 1: FIFO full.
- almost_empty, output, 1: count ≤ AE_LVL.
- almost_full, output, 1: count ≥ AF_LVL.
- count, output, AW+1 (AW = clog2(DEPTH)): current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; a write was attempted while full.
- underflow, output, 1: sticky; a read was attempted while empty.

Behaviour:
- Storage is an internal array of DEPTH x DW registers. Read and write pointers are AW+1 bits wide; the extra MSB disambiguates wrap-around.
- Flag definitions:
  - empty = (rp == wp).
  - full = same low AW bits and differing MSB.
  - count = wp - rp, modulo 2^(AW+1).
- Write acceptance:
  - Accepted iff we & !full & !clr.
  - mem[wp] <= din and wp increments.
  - A write while full is dropped even if re is high that cycle.
- Read acceptance:
  - Accepted iff re & !empty & !clr.
  - rp increments.
  - A read while empty is dropped even if we is high that cycle.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- Pointers wrap naturally at 2^(AW+1); no special handling is needed.
- Standard mode (FWFT=0):
  - On an accepted read at edge k, dout <= mem[rp] at edge k.
  - dout_vld is high for the cycle following edge k, otherwise low.
  - dout holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - dout = mem[rp] combinationally; dout_vld = !empty.
  - re acts as an acknowledge/pop.
  - A word written at edge k becomes visible on dout after edge k (zero added latency).
- Overflow and underflow:
  - overflow is set at the edge where we & full & !clr.
  - underflow is set at the edge where re & empty & !clr.
  - Both hold until rst or clr.
- almost_full and almost_empty are combinational from count. They may both be high if the thresholds overlap.
- Reset (async rst high): output values take effect immediately, without waiting for a clock edge.
  - rp = wp = 0, count = 0, dout = 0, dout_vld = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-transfer discards all stored data.
- clr (synchronous) gives the same end state as rst at the next edge, except dout keeps its value.
  - clr has priority over we and re in the same cycle.
  - Ops in that cycle are ignored and do not set error flags.
- No combinational path from we/re to full/empty/count; all of these change only after a clock edge.

Test Plan:
- Reset flags: assert rst asynchronously mid-cycle with the FIFO holding 5 words.
  - Required: outputs immediately show empty=1, count=0, dout_vld=0, overflow=0.
- Fill and overflow: DEPTH=16, write 0x00..0x10 (17 writes).
  - Required: almost_full rises when count reaches 14; full=1 and count=16 after the 16th write; overflow=1 after the 17th write.
  - Then read 16 words (FWFT=0). Required: dout sequence 0x00..0x0F with dout_vld one cycle after each read; 0x10 is absent.
- Underflow: read on an empty FIFO.
  - Required: underflow=1, count stays 0, rp unchanged.
  - A later write plus read returns the written value; underflow stays 1 until clr.
- Simultaneous read/write at boundaries:
  - With count=16, drive we=re=1. Required: the write is dropped, the read is accepted, count=15, overflow set.
  - With count=0, drive we=re=1. Required: the write is accepted, the read is dropped, count=1, underflow set.
- FWFT (FWFT=1): write 0xA5A5A5A5 at edge k.
  - Required: dout=0xA5A5A5A5 and dout_vld=1 after edge k.
  - Pop with re. Required: dout_vld=0 and empty=1 after the next edge.
- Wrap-around and clr:
  - Run 40 random interleaved read/write cycles. Required: reads are in order against a scoreboard, and count equals the model value every cycle.
  - Then assert clr with we=1. Required: count=0, empty=1, error flags cleared, no write stored.
